// File: rtl/if_slot_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if_slot_ctrl_pkg
// Shared definitions for the IF-stage slot sequencer: FSM state encodings,
// the pipeline NOP encoding, the default register-code width and a small
// helper used to size the shared down-counter.
// ---------------------------------------------------------------------------
package if_slot_ctrl_pkg;

    // Default register-code width (R0-R7, SP, IH, T, RA).
    localparam int REG_W_DEF = 4;

    // Instruction word written into pipeline registers to create a bubble.
    localparam logic [15:0] NOP = 16'h0800;

    // Sequencer states. The unused code 2'd3 is decoded as BOOT.
    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_RAM_BUSY = 2'd2
    } slot_state_e;

    // Larger of two integers, used for counter sizing.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/if_slot_ctrl_slot_counter.sv
// ---------------------------------------------------------------------------
// slot_counter
// Loadable down-counter with zero flag. One instance is shared by the BOOT
// hold and the multi-cycle RAM access, since the two never overlap.
// Ports:
//   CLK        in  clock, rising edge
//   RSTboot    in  asynchronous active-low reset (loads RST_VAL)
//   load_i     in  load load_val_i (takes priority over decrement)
//   load_val_i in  value to load
//   dec_i      in  decrement by one, saturating at zero
//   zero_o     out counter is currently zero
// ---------------------------------------------------------------------------
module slot_counter #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RSTboot,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTboot) begin
        if (!RSTboot) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/if_slot_ctrl.sv
// ---------------------------------------------------------------------------
// if_slot_ctrl
// Hazard and slot sequencer for the 5-stage 16-bit pipeline. Generates the
// IF/ID hold (loadSlot) and NOP insert (ramSlot), PC hold, ID/EX bubble,
// MEM-side freeze and the shared instruction/data RAM owner select.
// Handles load-use stalls, MEM-stage accesses to the shared RAM (single or
// multi-cycle) and a post-reset boot hold.
// Ports:
//   CLK, RSTboot            clock / async active-low reset
//   id_rs, id_rs_valid      source A of the ID instruction and its use flag
//   id_rt, id_rt_valid      source B of the ID instruction and its use flag
//   ex_mem_read, ex_rd      EX instruction is a load, and its destination
//   mem_req, mem_shared     MEM instruction accesses memory / the shared RAM
//   loadSlot, ramSlot       IF/ID hold / IF/ID NOP insert
//   pc_hold, idex_bubble    PC freeze / ID/EX NOP insert
//   mem_hold                freeze ID/EX and EX/MEM during a long access
//   ram_data_sel            1 = MEM stage owns the shared RAM
// ---------------------------------------------------------------------------
module if_slot_ctrl
    import if_slot_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int RAM_CYCLES  = 1,
    parameter int BOOT_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RSTboot,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_valid,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_req,
    input  logic             mem_shared,
    output logic             loadSlot,
    output logic             ramSlot,
    output logic             pc_hold,
    output logic             idex_bubble,
    output logic             mem_hold,
    output logic             ram_data_sel
);

    localparam int CNT_W = cnt_width(max_int(BOOT_CYCLES, RAM_CYCLES));
    localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES - 1);
    // The first access cycle is spent in RUN, so RAM_BUSY covers the rest.
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'((RAM_CYCLES > 1) ? RAM_CYCLES - 2 : 0);
    localparam bit MULTI_CYCLE = (RAM_CYCLES > 1);

    slot_state_e state_q;
    slot_state_e state_d;

    logic lu;
    logic rc;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    // Load-use hazard: the EX load writes a register the ID instruction reads.
    always_comb begin
        lu = ex_mem_read &&
             ((id_rs_valid && (id_rs == ex_rd)) ||
              (id_rt_valid && (id_rt == ex_rd)));
    end

    assign rc = mem_req && mem_shared;

    slot_counter #(
        .W       (CNT_W),
        .RST_VAL (BOOT_LOAD)
    ) u_slot_counter (
        .CLK        (CLK),
        .RSTboot    (RSTboot),
        .load_i     (cnt_load),
        .load_val_i (BUSY_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RSTboot) begin
        if (!RSTboot) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        loadSlot     = 1'b0;
        ramSlot      = 1'b0;
        pc_hold      = 1'b0;
        idex_bubble  = 1'b0;
        mem_hold     = 1'b0;
        ram_data_sel = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (rc) begin
                    ram_data_sel = 1'b1;
                    pc_hold      = 1'b1;
                    if (MULTI_CYCLE) begin
                        mem_hold = 1'b1;
                        loadSlot = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = ST_RAM_BUSY;
                    end else begin
                        ramSlot = 1'b1;
                    end
                end
                // A load-use stall waits while the MEM side is frozen; it is
                // picked up again in the final access cycle.
                if (lu && !(rc && MULTI_CYCLE)) begin
                    loadSlot    = 1'b1;
                    pc_hold     = 1'b1;
                    idex_bubble = 1'b1;
                end
            end

            ST_RAM_BUSY: begin
                ram_data_sel = 1'b1;
                pc_hold      = 1'b1;
                if (!cnt_zero) begin
                    mem_hold = 1'b1;
                    loadSlot = 1'b1;
                    cnt_dec  = 1'b1;
                end else begin
                    ramSlot = 1'b1;
                    state_d = ST_RUN;
                    if (lu) begin
                        loadSlot    = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
            end

            default: begin
                // BOOT, and the illegal code 2'd3 which behaves as BOOT.
                ramSlot = 1'b1;
                pc_hold = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        // IF/ID gives ramSlot precedence, so a held ID instruction must not
        // see a NOP insert. The lost fetch is harmless as the PC is held.
        if (loadSlot) begin
            ramSlot = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_slot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_slot_ctrl
// Drives two sequencers side by side from the same inputs: one with
// single-cycle shared-RAM accesses and one with three-cycle accesses.
// Each directed vector pushes the expected outputs of both into a queue;
// a monitor pops one entry per cycle and compares on the falling edge.
// Output vector bit order: {loadSlot, ramSlot, pc_hold, idex_bubble,
//                           mem_hold, ram_data_sel}
// ---------------------------------------------------------------------------
module tb_if_slot_ctrl;

    localparam logic [5:0] IDLE  = 6'b000000;
    localparam logic [5:0] BOOTV = 6'b011000;
    localparam logic [5:0] LU    = 6'b101100;
    localparam logic [5:0] RC1   = 6'b011001;
    localparam logic [5:0] HOLD  = 6'b101011;
    localparam logic [5:0] FIN   = 6'b011001;
    localparam logic [5:0] RCLU  = 6'b101101;

    logic       CLK = 1'b0;
    logic       RSTboot;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_rs_valid, id_rt_valid, ex_mem_read, mem_req, mem_shared;

    logic l1, r1, p1, b1, m1, s1;
    logic l3, r3, p3, b3, m3, s3;

    int checks   = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    typedef struct {
        string      name;
        logic [5:0] e1;
        logic [5:0] e3;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    if_slot_ctrl #(.REG_W(4), .RAM_CYCLES(1), .BOOT_CYCLES(4)) dut1 (
        .CLK(CLK), .RSTboot(RSTboot),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_shared(mem_shared),
        .loadSlot(l1), .ramSlot(r1), .pc_hold(p1),
        .idex_bubble(b1), .mem_hold(m1), .ram_data_sel(s1)
    );

    if_slot_ctrl #(.REG_W(4), .RAM_CYCLES(3), .BOOT_CYCLES(4)) dut3 (
        .CLK(CLK), .RSTboot(RSTboot),
        .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .id_rt(id_rt), .id_rt_valid(id_rt_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_shared(mem_shared),
        .loadSlot(l3), .ramSlot(r3), .pc_hold(p3),
        .idex_bubble(b3), .mem_hold(m3), .ram_data_sel(s3)
    );

    // One vector = one clock cycle of inputs plus the expected outputs.
    task automatic vec(input string nm, input logic rstn,
                       input logic mr, input logic [3:0] rd,
                       input logic [3:0] rs, input logic rsv,
                       input logic [3:0] rt, input logic rtv,
                       input logic mreq, input logic msh,
                       input logic [5:0] e1, input logic [5:0] e3);
        exp_t e;
        @(posedge CLK);
        #1;
        RSTboot     = rstn;
        ex_mem_read = mr;
        ex_rd       = rd;
        id_rs       = rs;
        id_rs_valid = rsv;
        id_rt       = rt;
        id_rt_valid = rtv;
        mem_req     = mreq;
        mem_shared  = msh;
        e.name = nm;
        e.e1   = e1;
        e.e3   = e3;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic rstn,
                        input logic [5:0] e1, input logic [5:0] e3);
        vec(nm, rstn, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0, e1, e3);
    endtask

    // Monitor: pops and compares whenever an expected entry is pending.
    initial begin : monitor
        exp_t       e;
        logic [5:0] a1, a3;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                a1 = {l1, r1, p1, b1, m1, s1};
                a3 = {l3, r3, p3, b3, m3, s3};
                checks += 2;
                if (a1 !== e.e1) begin
                    failures++;
                    $display("FAIL %s ram1: got %b expected %b", e.name, a1, e.e1);
                end
                if (a3 !== e.e3) begin
                    failures++;
                    $display("FAIL %s ram3: got %b expected %b", e.name, a3, e.e3);
                end
                $display("tx %-10s ram1=%b ram3=%b", e.name, a1, a3);
            end
        end
    end

    initial begin : stimulus
        RSTboot     = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = 4'd0;
        id_rs       = 4'd0;
        id_rs_valid = 1'b0;
        id_rt       = 4'd0;
        id_rt_valid = 1'b0;
        mem_req     = 1'b0;
        mem_shared  = 1'b0;

        // Reset values, then boot hold of exactly four cycles.
        idle("rst0", 0, BOOTV, BOOTV);
        idle("rst1", 0, BOOTV, BOOTV);
        idle("boot0", 1, BOOTV, BOOTV);
        idle("boot1", 1, BOOTV, BOOTV);
        vec("boot2_ign", 1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 1, 1, BOOTV, BOOTV);
        idle("boot3", 1, BOOTV, BOOTV);
        idle("run_idle", 1, IDLE, IDLE);

        // Load-use hazard variants.
        vec("lu_rs", 1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 0, 0, LU, LU);
        idle("idle_a", 1, IDLE, IDLE);
        vec("rt_inval", 1, 1, 4'd5, 4'd2, 1, 4'd5, 0, 0, 0, IDLE, IDLE);
        vec("rt_match", 1, 1, 4'd5, 4'd2, 1, 4'd5, 1, 0, 0, LU, LU);
        vec("no_load", 1, 0, 4'd5, 4'd5, 1, 4'd5, 1, 0, 0, IDLE, IDLE);
        vec("not_shrd", 1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0, IDLE, IDLE);

        // Single shared-RAM request.
        vec("rc_a", 1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1, RC1, HOLD);
        idle("rc_b", 1, IDLE, HOLD);
        idle("rc_c", 1, IDLE, FIN);
        idle("rc_d", 1, IDLE, IDLE);

        // Request together with a load-use hazard held for three cycles.
        vec("rclu_a", 1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 1, 1, RCLU, HOLD);
        vec("rclu_b", 1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 0, 0, LU, HOLD);
        vec("rclu_c", 1, 1, 4'd3, 4'd3, 1, 4'd0, 0, 0, 0, LU, RCLU);
        idle("rclu_d", 1, IDLE, IDLE);

        // Reset in the middle of an access, then a full boot replay.
        vec("ra_a", 1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1, RC1, HOLD);
        idle("ra_rst", 0, BOOTV, BOOTV);
        idle("ra_rst2", 0, BOOTV, BOOTV);
        idle("rb0", 1, BOOTV, BOOTV);
        idle("rb1", 1, BOOTV, BOOTV);
        idle("rb2", 1, BOOTV, BOOTV);
        idle("rb3", 1, BOOTV, BOOTV);
        idle("rb_run", 1, IDLE, IDLE);
        vec("rd_a", 1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1, RC1, HOLD);
        idle("rd_b", 1, IDLE, HOLD);
        idle("rd_c", 1, IDLE, FIN);
        idle("rd_d", 1, IDLE, IDLE);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge CLK);
        end
        @(posedge CLK);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus not finished, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
